// File: rtl/seq_div.sv
// Sequential restoring divider: operands loaded byte-wise from sw by button strobes,
// one quotient bit produced per clock, results held on registered outputs.
module seq_div #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [VW-1:0] sw,
    input  logic [3:0]    btn,
    output logic [DW-1:0] quo,
    output logic [VW-1:0] rem,
    output logic          busy,
    output logic          done,
    output logic          dbz
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] dividend, dividend_ld;
    logic [VW-1:0] divisor;
    logic [DW-1:0] wq, wq_nx;
    logic [VW-1:0] prem, prem_nx;
    logic [VW:0]   t, t_sub;
    logic [CW-1:0] cnt;
    logic          btn3_q;
    logic          start_pulse;
    logic          qbit;
    logic          last;

    always_comb begin
        start_pulse = btn[3] & ~btn3_q;
        last        = (cnt == CW'(DW - 1));

        // One restoring step: the partial remainder keeps its carry bit through the compare.
        t     = {prem, wq[DW-1]};
        t_sub = t - {1'b0, divisor};
        if (t >= {1'b0, divisor}) begin
            qbit    = 1'b1;
            prem_nx = t_sub[VW-1:0];
        end else begin
            qbit    = 1'b0;
            prem_nx = t[VW-1:0];
        end
        wq_nx = {wq[DW-2:0], qbit};

        dividend_ld = dividend;
        for (int b = 0; b < 2; b++) begin
            if (b < DW / 8 && btn[b]) dividend_ld[b*8 +: 8] = sw;
        end

        state_nx = state;
        case (state)
            IDLE: begin
                if (start_pulse) state_nx = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            wq       <= '0;
            prem     <= '0;
            cnt      <= '0;
            btn3_q   <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dbz      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            btn3_q <= btn[3];
            state  <= state_nx;
            done   <= (state_nx == DONE);
            busy   <= (state_nx == CALC);
            case (state)
                IDLE: begin
                    dividend <= dividend_ld;
                    if (btn[2]) divisor <= sw;
                    if (start_pulse) begin
                        if (divisor == '0) begin
                            quo <= '1;
                            rem <= dividend[VW-1:0];
                            dbz <= 1'b1;
                        end else begin
                            dbz  <= 1'b0;
                            wq   <= dividend;
                            prem <= '0;
                            cnt  <= '0;
                        end
                    end
                end
                CALC: begin
                    wq   <= wq_nx;
                    prem <= prem_nx;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        quo <= wq_nx;
                        rem <= prem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed corner cases plus random operands, scored against
// plain integer division and the dividend == quo*divisor + rem invariant.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sw = '0;
    logic [3:0]  btn = '0;
    logic [15:0] quo;
    logic [7:0]  rem;
    logic        busy, done, dbz;

    int n_chk = 0;
    int n_pass = 0;

    // operands as the bench believes the DUT holds them, and the last published result
    logic [15:0] m_dividend = '0;
    logic [7:0]  m_divisor = '0;
    logic [15:0] prev_q = '0;
    logic [7:0]  prev_r = '0;
    logic [24:0] exp_q[$];

    seq_div #(.DW(16), .VW(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
        .quo(quo), .rem(rem), .busy(busy), .done(done), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic load_ops(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] dv);
        @(negedge clk); sw = lo; btn = 4'b0001;
        @(negedge clk); sw = hi; btn = 4'b0010;
        @(negedge clk); sw = dv; btn = 4'b0100;
        @(negedge clk); btn = 4'b0000; sw = $urandom_range(0, 255);
        m_dividend = {hi, lo};
        m_divisor  = dv;
    endtask

    task automatic run_op(input string tag, input int hold, input bit scribble);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edbz;
        logic [24:0] e;
        int lat, ndone, nbusy, bad, limit;
        logic [31:0] prod;
        if (m_divisor == 0) begin
            eq = 16'hFFFF; er = m_dividend[7:0]; edbz = 1'b1;
        end else begin
            eq = m_dividend / m_divisor;
            er = 8'(m_dividend % m_divisor);
            edbz = 1'b0;
        end
        exp_q.push_back({edbz, eq, er});
        lat = 0; ndone = 0; nbusy = 0; bad = 0;
        limit = (hold > 20) ? hold + 3 : 20;
        @(negedge clk); btn[3] = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            if (busy) nbusy++;
            if (lat == 0 && (quo !== prev_q || rem !== prev_r || dbz !== 1'b0)) bad++;
            if (n >= hold) btn[3] = 1'b0;
            if (scribble && n <= 15) begin
                btn[2:0] = 3'($urandom_range(0, 7));
                sw = 8'($urandom_range(0, 255));
            end else begin
                btn[2:0] = 3'b000;
            end
        end
        btn = 4'b0000;
        e = exp_q.pop_front();
        check_val({tag, "_latency"}, lat, (m_divisor == 0) ? 1 : 17);
        check_val({tag, "_done_count"}, ndone, 1);
        check_val({tag, "_busy_cycles"}, nbusy, (m_divisor == 0) ? 0 : 16);
        check_val({tag, "_stable_before_done"}, bad, 0);
        check_val({tag, "_quo"}, quo, e[23:8]);
        check_val({tag, "_rem"}, rem, e[7:0]);
        check_val({tag, "_dbz"}, dbz, e[24]);
        if (m_divisor != 0) begin
            prod = quo * m_divisor + rem;
            check_val({tag, "_invariant"}, (prod == m_dividend && rem < m_divisor), 1);
        end
        prev_q = e[23:8];
        prev_r = e[7:0];
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_quo"}, quo, 0);
        check_val({tag, "_rem"}, rem, 0);
        check_val({tag, "_dbz"}, dbz, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        load_ops(8'hFF, 8'hFF, 8'hFF);  run_op("t1_ffff_ff", 1, 1'b0);
        load_ops(8'hE8, 8'h03, 8'h07);  run_op("t2_1000_7", 1, 1'b0);
        load_ops(8'h05, 8'h00, 8'h0A);  run_op("t3_small", 1, 1'b0);
        load_ops(8'h34, 8'h12, 8'h01);  run_op("t3_div1", 1, 1'b0);
        load_ops(8'hAB, 8'h12, 8'h00);  run_op("t4_dbz", 1, 1'b0);
        load_ops(8'h39, 8'h30, 8'h0D);  run_op("t4_after_dbz", 1, 1'b0);
        load_ops(8'h10, 8'hC7, 8'h35);  run_op("t5_hold", 40, 1'b0);
        load_ops(8'h77, 8'hA1, 8'h2B);  run_op("t5_scribble", 1, 1'b1);
        // the scribbled loads must not have reached the operand registers
        run_op("t5_rerun", 1, 1'b0);

        // reset in the middle of the calculation
        load_ops(8'h21, 8'h43, 8'h09);
        @(negedge clk); btn[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            btn[3] = 1'b0;
        end
        check_val("t6_busy_mid_calc", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("t6_mid_reset");
        rst_n = 1'b1;
        m_dividend = '0; m_divisor = '0; prev_q = '0; prev_r = '0;
        run_op("t6_zero_after_reset", 1, 1'b0);
        load_ops(8'h21, 8'h43, 8'h09);  run_op("t6_restart", 1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] lo, hi, dv;
            lo = 8'($urandom_range(0, 255));
            hi = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0:       dv = 8'h00;
                1, 2:    dv = 8'($urandom_range(1, 4));
                3:       dv = 8'($urandom_range(250, 255));
                default: dv = 8'($urandom_range(0, 255));
            endcase
            load_ops(lo, hi, dv);
            run_op("rand", 1, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
